// File: rtl/score_bcd_counter.sv
// Four-digit packed-BCD score counter with a digit-serial adder, saturation, a one-deep event
// buffer, and an optional high-score register that is built only when SCORE_HISCORE_EN is defined.
module score_bcd_counter #(
  parameter logic [15:0] SAT_VALUE = 16'h9999
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        game_clear,
  input  logic        eat,
  input  logic [3:0]  points,
  input  logic        game_over,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SAT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic        carry_q, carry_d;
  logic [3:0]  addend_q, addend_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] score_q, score_d;
  logic        commit_q, commit_d;
  logic        pend_q, pend_d;
  logic [3:0]  pend_pts_q, pend_pts_d;
  logic        ovf_q, ovf_d;
  logic        eat_prev_q, eat_arm_q;

  logic        eat_evt;
  logic [3:0]  pts_norm;
  logic [3:0]  cur_digit;
  logic [3:0]  add_in;
  logic [4:0]  dsum;
  logic [4:0]  dsum_adj;
  logic        dgt_carry;
  logic [15:0] acc_new;
  logic        over_sat;
  logic        busy_int;

  // The arm bit keeps an eat line held high across reset from counting as a new edge.
  assign eat_evt  = eat & ~eat_prev_q & eat_arm_q;
  assign pts_norm = ((points == 4'd0) || (points > 4'd9)) ? 4'd1 : points;

  always_comb begin
    cur_digit = acc_q[3:0];
    case (digit_q)
      2'd0: cur_digit = acc_q[3:0];
      2'd1: cur_digit = acc_q[7:4];
      2'd2: cur_digit = acc_q[11:8];
      2'd3: cur_digit = acc_q[15:12];
      default: cur_digit = acc_q[3:0];
    endcase
  end

  assign add_in    = (digit_q == 2'd0) ? addend_q : 4'd0;
  assign dsum      = {1'b0, cur_digit} + {1'b0, add_in} + {4'd0, carry_q};
  assign dgt_carry = (dsum > 5'd9);
  assign dsum_adj  = dgt_carry ? (dsum - 5'd10) : dsum;

  always_comb begin
    acc_new = acc_q;
    case (digit_q)
      2'd0: acc_new[3:0]   = dsum_adj[3:0];
      2'd1: acc_new[7:4]   = dsum_adj[3:0];
      2'd2: acc_new[11:8]  = dsum_adj[3:0];
      2'd3: acc_new[15:12] = dsum_adj[3:0];
      default: acc_new = acc_q;
    endcase
  end

  // Packed BCD orders the same as binary, so a plain magnitude compare suffices.
  assign over_sat = (acc_new > SAT_VALUE);

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    carry_d    = carry_q;
    addend_d   = addend_q;
    acc_d      = acc_q;
    score_d    = score_q;
    commit_d   = 1'b0;
    pend_d     = pend_q;
    pend_pts_d = pend_pts_q;
    ovf_d      = ovf_q;

    if (commit_q) begin
      score_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d    = S_ADD;
          digit_d    = 2'd0;
          carry_d    = 1'b0;
          addend_d   = pend_pts_q;
          pend_d     = eat_evt;
          pend_pts_d = eat_evt ? pts_norm : pend_pts_q;
        end else if (eat_evt) begin
          state_d  = S_ADD;
          digit_d  = 2'd0;
          carry_d  = 1'b0;
          addend_d = pts_norm;
        end
      end
      S_ADD: begin
        acc_d   = acc_new;
        carry_d = dgt_carry;
        digit_d = digit_q + 2'd1;
        if (digit_q == 2'd3) begin
          if (dgt_carry || over_sat) begin
            state_d = S_SAT;
          end else begin
            state_d  = S_IDLE;
            commit_d = 1'b1;
          end
        end
      end
      S_SAT: begin
        acc_d   = SAT_VALUE;
        score_d = SAT_VALUE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Events landing mid-addition go to the single buffer slot, else they are lost.
    if ((state_q != S_IDLE) && eat_evt) begin
      if (!pend_q) begin
        pend_d     = 1'b1;
        pend_pts_d = pts_norm;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (game_clear) begin
      state_d  = S_IDLE;
      digit_d  = 2'd0;
      carry_d  = 1'b0;
      acc_d    = 16'h0000;
      score_d  = 16'h0000;
      commit_d = 1'b0;
      pend_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= S_IDLE;
      digit_q    <= 2'd0;
      carry_q    <= 1'b0;
      addend_q   <= 4'd0;
      acc_q      <= 16'h0000;
      score_q    <= 16'h0000;
      commit_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_pts_q <= 4'd0;
      ovf_q      <= 1'b0;
      eat_prev_q <= 1'b0;
      eat_arm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      carry_q    <= carry_d;
      addend_q   <= addend_d;
      acc_q      <= acc_d;
      score_q    <= score_d;
      commit_q   <= commit_d;
      pend_q     <= pend_d;
      pend_pts_q <= pend_pts_d;
      ovf_q      <= ovf_d;
      eat_prev_q <= eat;
      if (!eat) begin
        eat_arm_q <= 1'b1;
      end
    end
  end

  assign busy_int    = (state_q != S_IDLE) || pend_q;
  assign busy        = busy_int;
  assign score       = score_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

`ifdef SCORE_HISCORE_EN
  logic        go_prev_q, go_arm_q;
  logic        go_wait_q, go_wait_d;
  logic [15:0] hs_q, hs_d;
  logic        go_evt;

  assign go_evt = game_over & ~go_prev_q & go_arm_q;

  // A game-over request waits until no addition is running or awaiting commit.
  always_comb begin
    go_wait_d = go_wait_q | go_evt;
    hs_d      = hs_q;
    if (go_wait_d && !busy_int && !commit_q) begin
      if (score_q > hs_q) begin
        hs_d = score_q;
      end
      go_wait_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      go_prev_q <= 1'b0;
      go_arm_q  <= 1'b0;
      go_wait_q <= 1'b0;
      hs_q      <= 16'h0000;
    end else begin
      go_prev_q <= game_over;
      go_wait_q <= go_wait_d;
      hs_q      <= hs_d;
      if (!game_over) begin
        go_arm_q <= 1'b1;
      end
    end
  end

  assign high_score = hs_q;
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
  assign high_score       = 16'h0000;
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter: score updates are checked by a queue-driven monitor,
// flags and the high-score path by inline checks.
module tb_score_bcd_counter;

  logic        clk;
  logic        rst_n;
  logic        game_clear;
  logic        eat;
  logic [3:0]  points;
  logic        game_over;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        busy;
  logic        overflow;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_q[$];
  int          exp_t_q[$];
  logic [15:0] prev_score = 16'h0000;

  score_bcd_counter #(.SAT_VALUE(16'h9999)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .game_clear (game_clear),
    .eat        (eat),
    .points     (points),
    .game_over  (game_over),
    .score      (score),
    .high_score (high_score),
    .busy       (busy),
    .overflow   (overflow),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every change of score consumes one expected entry (value and cycle)
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_score = score;
    end else if (score !== prev_score) begin
      prev_score = score;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL score_unexpected act=%h at cyc=%0d (nothing expected)", score, cyc);
      end else begin
        logic [15:0] e;
        int          t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        if (score !== e || cyc != t) begin
          bad++;
          $display("FAIL score_update act=%h exp=%h cyc=%0d exp_cyc=%0d", score, e, cyc, t);
        end
      end
    end
  end

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(logic [15:0] v, int t);
    exp_q.push_back(v);
    exp_t_q.push_back(t);
  endtask

  // driver: one-cycle eat pulse, expected score 5 cycles after the sampling edge
  task automatic add_ev(logic [3:0] p, logic [15:0] exp);
    push_exp(exp, cyc + 6);
    eat = 1'b1;
    points = p;
    tick(1);
    eat = 1'b0;
    tick(6);
  endtask

  task automatic do_clear();
    push_exp(16'h0000, cyc + 1);
    game_clear = 1'b1;
    tick(1);
    game_clear = 1'b0;
    tick(2);
  endtask

  logic [3:0]  ramp_pts [11] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
  logic [15:0] ramp_exp [11] = '{16'h0009, 16'h0018, 16'h0027, 16'h0036, 16'h0045, 16'h0054,
                                 16'h0063, 16'h0072, 16'h0081, 16'h0090, 16'h0098};
  logic [15:0] hs_exp_a, hs_exp_b;

  initial begin
`ifdef SCORE_HISCORE_EN
    hs_exp_a = 16'h0042;
    hs_exp_b = 16'h0051;
`else
    hs_exp_a = 16'h0000;
    hs_exp_b = 16'h0000;
`endif
    rst_n = 1'b0;
    game_clear = 1'b0;
    eat = 1'b0;
    points = 4'd1;
    game_over = 1'b0;
    tick(3);
    check("reset_score", score, 16'h0000);
    check("reset_high", high_score, 16'h0000);
    check("reset_busy", {15'd0, busy}, 16'h0000);
    check("reset_ovf", {15'd0, overflow}, 16'h0000);
    check("reset_state", {14'd0, dbg_state}, 16'h0000);
    rst_n = 1'b1;
    tick(3);

    // first event: latency and busy duration
    begin
      int bc;
      bc = 0;
      push_exp(16'h0001, cyc + 6);
      eat = 1'b1;
      points = 4'd1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        eat = 1'b0;
        if (busy) bc++;
      end
      check("busy_cycles", 16'(bc), 16'd4);
    end

    // out-of-range points count as 1
    add_ev(4'd0, 16'h0002);
    add_ev(4'd12, 16'h0003);

    // high score capture, unaffected by clear
    add_ev(4'd9, 16'h0012);
    add_ev(4'd9, 16'h0021);
    add_ev(4'd9, 16'h0030);
    add_ev(4'd9, 16'h0039);
    add_ev(4'd3, 16'h0042);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    tick(3);
    check("hs_capture", high_score, hs_exp_a);
    do_clear();
    check("hs_after_clear", high_score, hs_exp_a);
    check("ovf_clean", {15'd0, overflow}, 16'h0000);

    // ramp to 0098, then double carry
    for (int i = 0; i < 11; i++) add_ev(ramp_pts[i], ramp_exp[i]);
    add_ev(4'd5, 16'h0103);

    // three edges two cycles apart: one buffered, one dropped
    do_clear();
    push_exp(16'h0001, cyc + 6);
    push_exp(16'h0002, cyc + 11);
    points = 4'd1;
    eat = 1'b1; tick(1);
    eat = 1'b0; tick(1);
    eat = 1'b1; tick(1);
    eat = 1'b0; tick(1);
    eat = 1'b1; tick(1);
    eat = 1'b0;
    tick(12);
    check("ovf_set", {15'd0, overflow}, 16'h0001);
    do_clear();
    check("ovf_cleared", {15'd0, overflow}, 16'h0000);

    // game_over edge while busy: compare waits for the addition
    add_ev(4'd9, 16'h0009);
    add_ev(4'd9, 16'h0018);
    add_ev(4'd9, 16'h0027);
    add_ev(4'd9, 16'h0036);
    add_ev(4'd9, 16'h0045);
    push_exp(16'h0051, cyc + 6);
    eat = 1'b1;
    points = 4'd6;
    tick(1);
    eat = 1'b0;
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    tick(10);
    check("hs_deferred", high_score, hs_exp_b);

    // ramp to 9995, then saturate through SAT
    do_clear();
    for (int i = 1; i <= 1110; i++) add_ev(4'd9, to_bcd(9 * i));
    add_ev(4'd5, 16'h9995);
    push_exp(16'h9999, cyc + 6);
    eat = 1'b1;
    points = 4'd7;
    tick(1);
    eat = 1'b0;
    tick(4);
    check("sat_state", {14'd0, dbg_state}, 16'h0002);
    tick(3);
    eat = 1'b1;
    points = 4'd1;
    tick(1);
    eat = 1'b0;
    tick(7);
    check("sat_hold", score, 16'h9999);
    check("sat_idle_busy", {15'd0, busy}, 16'h0000);

    // reset mid-addition with eat held high
    eat = 1'b1;
    points = 4'd3;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_score", score, 16'h0000);
    check("rst_high", high_score, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_state", {14'd0, dbg_state}, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    begin
      int bc;
      bc = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (busy) bc++;
      end
      check("held_eat_busy", 16'(bc), 16'd0);
    end
    check("held_eat_score", score, 16'h0000);
    eat = 1'b0;
    tick(2);
    add_ev(4'd3, 16'h0003);

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
